// File: rtl/imm_extend_pipe_if.sv
// Request/result bundle for the immediate-extension pipeline.
// The slave modport is the pipeline's view; the master modport is the driver's view.
interface imm_extend_pipe_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [2:0]            in_mode;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_illegal;

  modport slave (
    input  in_valid, in_instr, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extraction/extension unit: stage 1 captures the raw field,
// stage 2 extends, scales or halfword-shifts it to DATA_WIDTH.
module imm_extend_pipe #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned BR_SHIFT   = 1
) (
  input logic             clk,
  input logic             reset,
  input logic             flush,
  imm_extend_pipe_if.slave bus
);

  logic                  s1_valid_q;
  logic [25:0]           field_q;
  logic                  msb_q;
  logic [2:0]            mode_q;
  logic [1:0]            hw_q;
  logic [TAG_WIDTH-1:0]  tag1_q;

  logic                  s2_valid_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [TAG_WIDTH-1:0]  tag2_q;
  logic                  illegal_q;

  logic                  s2_load;
  logic                  s1_adv;
  logic [25:0]           field_d;
  logic                  msb_d;
  logic [DATA_WIDTH-1:0] imm_d;
  logic                  illegal_d;

  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_load;
  assign bus.in_ready = s1_adv;

  // Field is right-aligned; the sign bit travels separately so stage 2 needs no instr bits.
  always_comb begin
    field_d = '0;
    msb_d   = 1'b0;
    case (bus.in_mode)
      3'd0: begin
        field_d = {17'b0, bus.in_instr[20:12]};
        msb_d   = bus.in_instr[20];
      end
      3'd1: field_d = {14'b0, bus.in_instr[21:10]};
      3'd2: begin
        field_d = {7'b0, bus.in_instr[23:5]};
        msb_d   = bus.in_instr[23];
      end
      3'd3: begin
        field_d = bus.in_instr[25:0];
        msb_d   = bus.in_instr[25];
      end
      3'd4:    field_d = {10'b0, bus.in_instr[20:5]};
      3'd5:    field_d = {20'b0, bus.in_instr[15:10]};
      default: field_d = '0;
    endcase
  end

  always_comb begin
    imm_d     = '0;
    illegal_d = 1'b0;
    case (mode_q)
      3'd0: imm_d = {{(DATA_WIDTH - 9){msb_q}}, field_q[8:0]};
      3'd1: imm_d = DATA_WIDTH'(field_q[11:0]);
      3'd2: begin
        imm_d = {{(DATA_WIDTH - 19){msb_q}}, field_q[18:0]};
        if (BR_SHIFT != 0) imm_d = {imm_d[DATA_WIDTH-3:0], 2'b00};
      end
      3'd3: begin
        imm_d = {{(DATA_WIDTH - 26){msb_q}}, field_q[25:0]};
        if (BR_SHIFT != 0) imm_d = {imm_d[DATA_WIDTH-3:0], 2'b00};
      end
      // Halfwords shifted past DATA_WIDTH fall off the top.
      3'd4:    imm_d = DATA_WIDTH'(field_q[15:0]) << {hw_q, 4'b0000};
      3'd5:    imm_d = DATA_WIDTH'(field_q[5:0]);
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      field_q    <= '0;
      msb_q      <= 1'b0;
      mode_q     <= '0;
      hw_q       <= '0;
      tag1_q     <= '0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
      end else if (s1_adv) begin
        s1_valid_q <= bus.in_valid;
      end
      if (s1_adv && bus.in_valid && !flush) begin
        field_q <= field_d;
        msb_q   <= msb_d;
        mode_q  <= bus.in_mode;
        hw_q    <= bus.in_instr[22:21];
        tag1_q  <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      imm_q      <= '0;
      tag2_q     <= '0;
      illegal_q  <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid_q <= 1'b0;
      end else if (s2_load) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_load && s1_valid_q && !flush) begin
        imm_q     <= imm_d;
        tag2_q    <= tag1_q;
        illegal_q <= illegal_d;
      end
    end
  end

  assign bus.out_valid   = s2_valid_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_tag     = tag2_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: three configurations driven in lockstep, checked every cycle
// against an occupancy/arithmetic model of the pipeline.
module tb_imm_extend_pipe;
  localparam int unsigned TW = 4;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic [31:0]   in_instr  = '0;
  logic [2:0]    in_mode   = '0;
  logic [TW-1:0] in_tag    = '0;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.DATA_WIDTH(64), .TAG_WIDTH(TW)) ifa ();
  imm_extend_pipe_if #(.DATA_WIDTH(64), .TAG_WIDTH(TW)) ifb ();
  imm_extend_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(TW)) ifc ();

  assign ifa.in_valid = in_valid;
  assign ifa.in_instr = in_instr;
  assign ifa.in_mode  = in_mode;
  assign ifa.in_tag   = in_tag;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;
  assign ifb.in_instr = in_instr;
  assign ifb.in_mode  = in_mode;
  assign ifb.in_tag   = in_tag;
  assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;
  assign ifc.in_instr = in_instr;
  assign ifc.in_mode  = in_mode;
  assign ifc.in_tag   = in_tag;
  assign ifc.out_ready = out_ready;

  // a: 64-bit unscaled, b: 64-bit scaled, c: 32-bit scaled
  imm_extend_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(TW), .BR_SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .bus(ifa.slave));
  imm_extend_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(TW), .BR_SHIFT(1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .bus(ifb.slave));
  imm_extend_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(TW), .BR_SHIFT(1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .bus(ifc.slave));

  typedef struct {
    logic [31:0]   instr;
    logic [2:0]    mode;
    logic [TW-1:0] tag;
  } req_t;

  req_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          pushed = 0;
  int          popped = 0;
  int          flushed = 0;
  logic [31:0] vi[10];
  logic [2:0]  vm[10];

  function automatic logic [63:0] model(logic [31:0] ins, logic [2:0] mode, int dw, int brs);
    longint      v;
    logic [63:0] r;
    case (mode)
      3'd0: begin
        v = longint'(ins[20:12]);
        if (ins[20]) v = v - 512;
      end
      3'd1: v = longint'(ins[21:10]);
      3'd2: begin
        v = longint'(ins[23:5]);
        if (ins[23]) v = v - (longint'(1) << 19);
        if (brs != 0) v = v * 4;
      end
      3'd3: begin
        v = longint'(ins[25:0]);
        if (ins[25]) v = v - (longint'(1) << 26);
        if (brs != 0) v = v * 4;
      end
      3'd4: v = longint'(ins[20:5]) << (16 * int'(ins[22:21]));
      3'd5: v = longint'(ins[15:10]);
      default: v = 0;
    endcase
    r = 64'(v);
    if (dw < 64) r = r & ((64'd1 << dw) - 64'd1);
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cmp_dut(string nm, logic ov, logic [63:0] imm, logic [TW-1:0] tag, logic ill,
                         int dw, int brs);
    if (q.size() == 0) begin
      chk({nm, "_idle_valid"}, 64'(ov), 64'd0);
    end else if (ov) begin
      chk({nm, "_imm"}, imm, model(q[0].instr, q[0].mode, dw, brs));
      chk({nm, "_tag"}, 64'(tag), 64'(q[0].tag));
      chk({nm, "_illegal"}, 64'(ill), 64'(q[0].mode >= 3'd6));
    end
  endtask

  // Queue holds exactly the requests in flight; at most two can be held.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_imm   = '0;
  always @(negedge clk) begin
    if (!reset) begin
      flushed += q.size();
      q.delete();
      prev_stall = 1'b0;
      chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    end else begin
      logic exp_rdy;
      exp_rdy = !(q.size() == 2 && !out_ready);
      chk("occupancy", 64'(q.size() <= 2), 64'd1);
      chk("in_ready_a", 64'(ifa.in_ready), 64'(exp_rdy));
      chk("in_ready_c", 64'(ifc.in_ready), 64'(exp_rdy));
      cmp_dut("a", ifa.out_valid, ifa.out_imm, ifa.out_tag, ifa.out_illegal, 64, 0);
      cmp_dut("b", ifb.out_valid, ifb.out_imm, ifb.out_tag, ifb.out_illegal, 64, 1);
      cmp_dut("c", ifc.out_valid, 64'(ifc.out_imm), ifc.out_tag, ifc.out_illegal, 32, 1);
      if (prev_stall && ifa.out_valid) chk("stall_hold", ifa.out_imm, prev_imm);
      prev_stall = ifa.out_valid && !out_ready;
      prev_imm   = ifa.out_imm;
      if (ifa.out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        popped++;
      end
      if (flush) begin
        flushed += q.size();
        q.delete();
      end else if (in_valid && ifa.in_ready) begin
        q.push_back('{instr: in_instr, mode: in_mode, tag: in_tag});
        pushed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] ins, logic [2:0] mode, logic [TW-1:0] tag);
    bit ok;
    ok       = 1'b0;
    in_instr = ins;
    in_mode  = mode;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifa.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accepted", 64'(ok), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_block;
    vi[0] = 32'h0007_3200; vm[0] = 3'd2;  // imm19 = 14736
    vi[1] = 32'h00F8_CE00; vm[1] = 3'd2;  // imm19 = 0x7C670 (-14736)
    vi[2] = 32'h0000_0000; vm[2] = 3'd2;
    vi[3] = 32'h0200_0000; vm[3] = 3'd3;  // imm26 = 0x2000000
    vi[4] = 32'h0077_DDE0; vm[4] = 3'd4;  // 0xBEEF, hw 3
    vi[5] = 32'h0057_DDE0; vm[5] = 3'd4;  // 0xBEEF, hw 2
    vi[6] = 32'hFFFF_FFFF; vm[6] = 3'd1;
    vi[7] = 32'h001F_F000; vm[7] = 3'd0;  // imm9 = -1
    vi[8] = 32'hFFFF_FFFF; vm[8] = 3'd5;
    vi[9] = 32'hA5A5_5A5A; vm[9] = 3'd3;

    chk("pin_br0_pos", model(vi[0], 3'd2, 64, 0), 64'h0000_0000_0000_3990);
    chk("pin_br0_neg", model(vi[1], 3'd2, 64, 0), 64'hFFFF_FFFF_FFFF_C670);
    chk("pin_br0_zero", model(vi[2], 3'd2, 64, 0), 64'h0);
    chk("pin_br1_pos", model(vi[0], 3'd2, 64, 1), 64'h0000_0000_0000_E640);
    chk("pin_br1_neg", model(vi[1], 3'd2, 64, 1), 64'hFFFF_FFFF_FFFF_19C0);
    chk("pin_imm26", model(vi[3], 3'd3, 64, 1), 64'hFFFF_FFFF_F800_0000);
    chk("pin_hw3", model(vi[4], 3'd4, 64, 1), 64'hBEEF_0000_0000_0000);
    chk("pin_dw32_hw2", model(vi[5], 3'd4, 32, 1), 64'h0);
    chk("pin_imm12", model(vi[6], 3'd1, 64, 1), 64'h0000_0000_0000_0FFF);
    chk("pin_imm9", model(vi[7], 3'd0, 32, 1), 64'h0000_0000_FFFF_FFFF);

    #2;
    chk("rst_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_ready", 64'(ifa.in_ready), 64'd1);
    chk("rst_imm", ifa.out_imm, 64'd0);
    chk("rst_tag", 64'(ifa.out_tag), 64'd0);
    chk("rst_illegal", 64'(ifa.out_illegal), 64'd0);
    #21 reset = 1'b1;
    step();

    // Latency from an empty pipe.
    send(vi[0], vm[0], 4'd1);
    @(negedge clk);
    chk("lat1_valid", 64'(ifa.out_valid), 64'd0);
    @(negedge clk);
    chk("lat2_valid", 64'(ifa.out_valid), 64'd1);
    chk("lat2_imm_a", ifa.out_imm, 64'h3990);
    chk("lat2_imm_b", ifb.out_imm, 64'hE640);
    repeat (3) step();

    for (int i = 0; i < 10; i++) send(vi[i], vm[i], TW'(i));
    repeat (4) step();

    // Back-to-back stream with a three-cycle consumer stall.
    saw_block = 1'b0;
    fork
      for (int t = 0; t < 8; t++) send(vi[t], vm[t], TW'(t));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      repeat (14) begin
        @(negedge clk);
        if (!ifa.in_ready) saw_block = 1'b1;
      end
    join
    chk("stall_blocks_input", 64'(saw_block), 64'd1);
    repeat (4) step();
    chk("stream_drained", 64'(q.size()), 64'd0);

    // Flush with both stages full and a request pending.
    out_ready = 1'b0;
    send(vi[3], vm[3], 4'd9);
    send(vi[4], vm[4], 4'd10);
    in_instr = vi[5];
    in_mode  = vm[5];
    in_tag   = 4'd11;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_valid", 64'(ifa.out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (4) step();

    // Flush while input is open.
    send(vi[6], vm[6], 4'd12);
    in_instr = vi[7];
    in_mode  = vm[7];
    in_tag   = 4'd13;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_open_valid", 64'(ifa.out_valid), 64'd0);
    repeat (4) step();

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    send(vi[8], vm[8], 4'd1);
    send(vi[9], vm[9], 4'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(ifa.out_valid), 64'd0);
    chk("arst_ready", 64'(ifa.in_ready), 64'd1);
    chk("arst_imm", ifa.out_imm, 64'd0);
    chk("arst_tag", 64'(ifa.out_tag), 64'd0);
    chk("arst_illegal", 64'(ifa.out_illegal), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    out_ready = 1'b1;
    step();

    send(32'hFFFF_FFFF, 3'd6, 4'd5);
    @(negedge clk);
    @(negedge clk);
    chk("illegal_valid", 64'(ifa.out_valid), 64'd1);
    chk("illegal_flag", 64'(ifa.out_illegal), 64'd1);
    chk("illegal_imm", ifa.out_imm, 64'd0);
    chk("illegal_imm_c", 64'(ifc.out_imm), 64'd0);
    repeat (4) step();

    chk("final_empty", 64'(q.size()), 64'd0);
    chk("conservation", 64'(popped + flushed), 64'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extraction and extension unit for the decode stage.
- Replaces the fixed per-field sign extenders with one block.
- Takes a 32-bit instruction word and a field mode, extracts the immediate and sign- or zero-extends it to DATA_WIDTH, applying branch scaling and MOVZ/MOVK halfword shift.
- Two-stage registered pipeline with valid/ready handshake, flush and tag passthrough, so it can sit between fetch buffer and register read.

Parameters:
- DATA_WIDTH, 64, output width; legal range 32..64.
- TAG_WIDTH, 4, width of the opaque tag carried alongside each request.
- BR_SHIFT, 1, when 1 the imm19 and imm26 modes are shifted left by 2 after extension; when 0 they are unshifted.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; kills both pipeline stages
- in_valid  input  1  request present
- in_ready  output  1  block accepts request this cycle
- in_instr  input  32  instruction word
- in_mode  input  3  field select (see Behaviour)
- in_tag  input  TAG_WIDTH  opaque tag
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_imm  output  DATA_WIDTH  extended immediate
- out_tag  output  TAG_WIDTH  tag of the result
- out_illegal  output  1  in_mode was reserved

Behaviour:
- Modes and extraction:
  - 0: imm9 = instr[20:12], signed
  - 1: imm12 = instr[21:10], unsigned
  - 2: imm19 = instr[23:5], signed, scaled if BR_SHIFT
  - 3: imm26 = instr[25:0], signed, scaled if BR_SHIFT
  - 4: imm16 = instr[20:5], unsigned, shifted left by 16*instr[22:21]; bits beyond DATA_WIDTH are dropped
  - 5: shamt = instr[15:10], unsigned
  - 6, 7: reserved; out_imm = 0, out_illegal = 1
- Sign extension replicates the field MSB into every bit above the field.
- The BR_SHIFT scaling is applied after extension; the low 2 bits become 0.
- Stage 1 registers: raw field (26 bits), field MSB, mode, hw, tag, s1_valid.
- Stage 2 registers: extend/shift result, tag, illegal flag, s2_valid. out_* are driven directly from the stage-2 registers.
- Latency: exactly 2 cycles from an accepted request to out_valid when there is no backpressure. Throughput: 1 result per cycle.
- Handshake:
  - s2_load = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_load
  - in_ready = s1_adv (combinational, independent of in_valid)
  - A transfer happens on in_valid && in_ready, or on out_valid && out_ready.
- Stall: while out_valid && !out_ready, out_imm, out_tag and out_illegal hold stable, and stage 1 holds if it is full.
- Bubbles: an empty stage is filled even when the downstream stage is stalled, so a 2-deep backlog is absorbed.
- Flush: on the next edge s1_valid = 0 and s2_valid = 0.
  - Flush has priority over a simultaneous input transfer; the request presented in the flush cycle is dropped.
  - in_ready may be 1 during flush.
  - Data registers need not clear.
- Reset (asynchronous assert, any cycle including mid-stall): s1_valid = 0, s2_valid = 0, out_valid = 0, out_imm = 0, out_tag = 0, out_illegal = 0, in_ready = 1.
- Data registers update only when their stage loads, so no X values appear on out_imm while out_valid = 0 after reset.

Test Plan:
- Mode 2, field 14736, BR_SHIFT = 0 → out_imm 0x0000_0000_0000_3990 two cycles later. Field -14736 (0x7C670) → 0xFFFF_FFFF_FFFF_C670. Field 0 → 0.
- Mode 2 with BR_SHIFT = 1, same two fields → 0x0000_0000_0000_E640 and 0xFFFF_FFFF_FFFF_19C0. Mode 3, field 0x2000000 → 0xFFFF_FFFF_F800_0000.
- Mode 4, imm16 = 0xBEEF: hw = 3 → 0xBEEF_0000_0000_0000; DATA_WIDTH = 32 with hw = 2 → 0. Mode 1, imm12 = 0xFFF → 0xFFF, no sign extension.
- Back-to-back stream of tags 0..7 with out_ready low for cycles 3–5:
  - in_ready drops once two results are held.
  - Results emerge in order with matching tags; none lost or duplicated.
  - out_imm stays stable while stalled.
- Flush asserted while both stages are full and in_valid = 1 → next cycle out_valid = 0; neither the flushed items nor the flush-cycle request ever appear.
- reset pulled low mid-stall with both stages full → out_valid = 0 and in_ready = 1 asynchronously. Mode 6 request after release → out_illegal = 1, out_imm = 0.
